bin_to_bcd_seq: RTL

- Sequential binary-to-BCD converter for the ATM display and keypad-echo path. It is the inverse of the BCD-to-binary decode used on keypad entry.
- Takes a 32-bit unsigned binary value, such as an account balance or withdrawal amount, and produces 8 packed BCD digits using an iterative shift-add-3 (double-dabble) engine.
- Uses a start/busy/done handshake. Also reports the significant digit count, which the seven-segment driver uses for leading-zero blanking.

---
 rtl/bin_to_bcd_seq_if.sv | 26 ++
 rtl/bin_to_bcd_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq_if
// Brief    : Start/busy/done handshake and result bundle for bin_to_bcd_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if;
    logic        start;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;
    logic [3:0]  num_digits;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow, num_digits
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow, num_digits
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Iterative double-dabble converter, 32-bit binary to 8 BCD digits,
//            with saturation above MAX_VAL and significant-digit count.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int          DIGITS  = 8,
    parameter int          BIN_W   = 32,
    parameter int unsigned MAX_VAL = 99999999
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int                  c_cnt_w    = $clog2(BIN_W);
    localparam int                  c_bcd_w    = 4 * DIGITS;
    localparam logic [c_cnt_w-1:0]  c_last_cnt = c_cnt_w'(BIN_W - 1);
    localparam logic [BIN_W-1:0]    c_max_val  = BIN_W'(MAX_VAL);
    localparam logic [c_bcd_w-1:0]  c_sat_bcd  = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_FIN     = 2'd2,
        S_FIN_OVF = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [BIN_W-1:0]     bin_q,     bin_d;
    logic [c_bcd_w-1:0]   scratch_q, scratch_d;
    logic [c_cnt_w-1:0]   bit_cnt_q, bit_cnt_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [c_bcd_w-1:0]   bcd_q,     bcd_d;
    logic                 ovf_q,     ovf_d;
    logic [3:0]           ndig_q,    ndig_d;

    logic [c_bcd_w-1:0]   w_adj;
    logic [3:0]           w_ndig;

    always_comb begin
        w_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_ndig = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] != 4'd0) begin
                w_ndig = 4'(i + 1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        ndig_d    = ndig_q;

        case (state_q)
            S_IDLE: begin
                // The done cycle itself never accepts a start, so a held start
                // retriggers one edge later.
                if (bus.start && !done_q) begin
                    bin_d     = bus.bin_in;
                    scratch_d = '0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = (bus.bin_in > c_max_val) ? S_FIN_OVF : S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scratch_d, bin_d} = {w_adj, bin_q} << 1;
                bit_cnt_d          = bit_cnt_q + c_cnt_w'(1);
                if (bit_cnt_q == c_last_cnt) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                bcd_d   = scratch_q;
                ovf_d   = 1'b0;
                ndig_d  = w_ndig;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FIN_OVF: begin
                // Saturated result is published on the second cycle here,
                // giving the overflow path a fixed two-clock latency.
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = c_cnt_w'(1);
                end else begin
                    bcd_d   = c_sat_bcd;
                    ovf_d   = 1'b1;
                    ndig_d  = 4'(DIGITS);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            ndig_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            ndig_q    <= ndig_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.overflow   = ovf_q;
    assign bus.num_digits = ndig_q;
endmodule
`default_nettype wire
